adder_n: RTL and testbench

ADDER_N -- requirements
Module: adder_n

---
 rtl/adder_n_pkg.sv | 7 +
 rtl/adder_n_full_adder.sv | 13 +
 rtl/adder_n.sv | 68 ++++++
 tb/tb_adder_n.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_n_pkg.sv
// Shared width constants for the adder_n ripple-carry adder.
package adder_n_pkg;

    localparam int ADDER_N_DEFAULT_W = 4;
    localparam int ADDER_N_MAX_W     = 64;

endpackage

// File: rtl/adder_n_full_adder.sv
// One-bit full adder cell used as the ripple stage of adder_n.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/adder_n.sv
// N-bit ripple-carry adder: {c_out, sum} = a + b + c_in.
// Define ADDER_N_OUTPUT_REG_EN to register the outputs (1-cycle latency, async active-low reset).
module adder_n
    import adder_n_pkg::*;
#(
    parameter int N = ADDER_N_DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         c_out,
    output logic [N-1:0] sum
);

    if (N < 1 || N > ADDER_N_MAX_W) begin : g_bad_width
        $fatal(1, "adder_n: N=%0d outside legal range 1..%0d", N, ADDER_N_MAX_W);
    end

    logic [N:0]   carry;
    logic [N-1:0] sum_c;

    assign carry[0] = c_in;

    for (genvar i = 0; i < N; i++) begin : g_cell
        full_adder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i]),
            .sum   (sum_c[i]),
            .c_out (carry[i+1])
        );
    end

`ifdef ADDER_N_OUTPUT_REG_EN
    logic [N-1:0] sum_d;
    logic [N-1:0] sum_q;
    logic         c_out_d;
    logic         c_out_q;

    always_comb begin
        sum_d   = sum_c;
        c_out_d = carry[N];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
`else
    // Clock and reset have no role in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign sum   = sum_c;
    assign c_out = carry[N];
`endif

endmodule

// File: tb/tb_adder_n.sv
// Directed and sweep bench for adder_n at N=1, 3, 4 and 8.
module tb_adder_n;

    logic clk;
    logic rst_n;

    logic [0:0] a1, b1, s1;
    logic       ci1, co1;
    logic [2:0] a3, b3, s3;
    logic       ci3, co3;
    logic [3:0] a4, b4, s4;
    logic       ci4, co4;
    logic [7:0] a8, b8, s8;
    logic       ci8, co8;

    int checks;
    int errors;

    adder_n #(.N(1)) dut1 (.clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c_in(ci1), .c_out(co1), .sum(s1));
    adder_n #(.N(3)) dut3 (.clk(clk), .rst_n(rst_n), .a(a3), .b(b3), .c_in(ci3), .c_out(co3), .sum(s3));
    adder_n #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c_in(ci4), .c_out(co4), .sum(s4));
    adder_n #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c_in(ci8), .c_out(co8), .sum(s8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ADDER_N_OUTPUT_REG_EN
    // Registered build: outputs forced to zero while reset is low, across edges.
    task automatic test_reset();
        rst_n = 1'b0;
        a4 = 4'b1111; b4 = 4'b1111; ci4 = 1'b1;
        #1;
        checks++;
        if ({co4, s4} !== 5'b0_0000) begin
            errors++;
            $display("FAIL reset_immediate got=%b expected=%b", {co4, s4}, 5'b0_0000);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({co4, s4} !== 5'b0_0000) begin
            errors++;
            $display("FAIL reset_hold got=%b expected=%b", {co4, s4}, 5'b0_0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_registered();
        @(negedge clk);
        a4 = 4'b0011; b4 = 4'b0100; ci4 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({co4, s4} !== 5'b0_0111) begin
            errors++;
            $display("FAIL reg_first_load got=%b expected=%b", {co4, s4}, 5'b0_0111);
        end
        @(negedge clk);
        a4 = 4'b1001; b4 = 4'b0111; ci4 = 1'b0;
        #1;
        checks++;
        if ({co4, s4} !== 5'b0_0111) begin
            errors++;
            $display("FAIL reg_hold_before_edge got=%b expected=%b", {co4, s4}, 5'b0_0111);
        end
        @(posedge clk); #1;
        checks++;
        if ({co4, s4} !== 5'b1_0000) begin
            errors++;
            $display("FAIL reg_latency got=%b expected=%b", {co4, s4}, 5'b1_0000);
        end
        @(negedge clk);
        a4 = 4'b0101; b4 = 4'b0110; ci4 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({co4, s4} !== 5'b0_1100) begin
            errors++;
            $display("FAIL reg_back_to_back got=%b expected=%b", {co4, s4}, 5'b0_1100);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a4 = 4'b1111; b4 = 4'b1111; ci4 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({co4, s4} !== 5'b1_1111) begin
            errors++;
            $display("FAIL mid_preload got=%b expected=%b", {co4, s4}, 5'b1_1111);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({co4, s4} !== 5'b0_0000) begin
            errors++;
            $display("FAIL mid_reset_async got=%b expected=%b", {co4, s4}, 5'b0_0000);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({co4, s4} !== 5'b0_0000) begin
            errors++;
            $display("FAIL mid_reset_hold got=%b expected=%b", {co4, s4}, 5'b0_0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'b0010; b4 = 4'b0011; ci4 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({co4, s4} !== 5'b0_0101) begin
            errors++;
            $display("FAIL mid_release_load got=%b expected=%b", {co4, s4}, 5'b0_0101);
        end
    endtask
`else
    // Combinational build: reset must not disturb the sum.
    task automatic test_reset();
        rst_n = 1'b0;
        a3 = 3'b110; b3 = 3'b011; ci3 = 1'b1;
        #1;
        checks++;
        if ({co3, s3} !== 4'b1010) begin
            errors++;
            $display("FAIL comb_reset_low got=%b expected=%b", {co3, s3}, 4'b1010);
        end
        @(posedge clk); #1;
        checks++;
        if ({co3, s3} !== 4'b1010) begin
            errors++;
            $display("FAIL comb_reset_edge got=%b expected=%b", {co3, s3}, 4'b1010);
        end
        rst_n = 1'b1;
        a3 = 3'b001; b3 = 3'b001; ci3 = 1'b0;
        #1;
        checks++;
        if ({co3, s3} !== 4'b0010) begin
            errors++;
            $display("FAIL comb_reset_release got=%b expected=%b", {co3, s3}, 4'b0010);
        end
    endtask

    task automatic test_boundaries();
        a3 = 3'b111; b3 = 3'b111; ci3 = 1'b1;
        #1;
        checks++;
        if ({co3, s3} !== 4'b1111) begin
            errors++;
            $display("FAIL all_ones got=%b expected=%b", {co3, s3}, 4'b1111);
        end
        a3 = 3'b000; b3 = 3'b000; ci3 = 1'b0;
        #1;
        checks++;
        if ({co3, s3} !== 4'b0000) begin
            errors++;
            $display("FAIL all_zero got=%b expected=%b", {co3, s3}, 4'b0000);
        end
    endtask

    task automatic test_ripple();
        a3 = 3'b101; b3 = 3'b011; ci3 = 1'b0;
        #1;
        checks++;
        if ({co3, s3} !== 4'b1000) begin
            errors++;
            $display("FAIL full_ripple got=%b expected=%b", {co3, s3}, 4'b1000);
        end
        a3 = 3'b010; b3 = 3'b001; ci3 = 1'b1;
        #1;
        checks++;
        if ({co3, s3} !== 4'b0100) begin
            errors++;
            $display("FAIL carry_in got=%b expected=%b", {co3, s3}, 4'b0100);
        end
    endtask

    task automatic test_sweep_n3();
        logic [3:0] exp;
        for (int ia = 0; ia < 8; ia++) begin
            for (int ib = 0; ib < 8; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a3 = 3'(ia); b3 = 3'(ib); ci3 = 1'(ic);
                    exp = 4'(ia + ib + ic);
                    #1;
                    checks++;
                    if ({co3, s3} !== exp) begin
                        errors++;
                        $display("FAIL sweep_n3 a=%0d b=%0d ci=%0d got=%b expected=%b", ia, ib, ic, {co3, s3}, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_sweep_n1();
        logic [1:0] exp;
        for (int v = 0; v < 8; v++) begin
            a1 = 1'(v >> 2); b1 = 1'(v >> 1); ci1 = 1'(v);
            exp = 2'(((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1));
            #1;
            checks++;
            if ({co1, s1} !== exp) begin
                errors++;
                $display("FAIL sweep_n1 v=%0d got=%b expected=%b", v, {co1, s1}, exp);
            end
        end
    endtask

    task automatic test_random_n8();
        logic [8:0] exp;
        a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1;
        #1;
        checks++;
        if ({co8, s8} !== 9'h100) begin
            errors++;
            $display("FAIL n8_carry_chain got=%h expected=%h", {co8, s8}, 9'h100);
        end
        for (int i = 0; i < 10000; i++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            ci8 = 1'($urandom_range(0, 1));
            exp = {1'b0, a8} + {1'b0, b8} + {8'b0, ci8};
            #1;
            checks++;
            if ({co8, s8} !== exp) begin
                errors++;
                $display("FAIL random_n8 a=%h b=%h ci=%b got=%h expected=%h", a8, b8, ci8, {co8, s8}, exp);
            end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        a1 = '0; b1 = '0; ci1 = 1'b0;
        a3 = '0; b3 = '0; ci3 = 1'b0;
        a4 = '0; b4 = '0; ci4 = 1'b0;
        a8 = '0; b8 = '0; ci8 = 1'b0;
        #2;
        test_reset();
`ifdef ADDER_N_OUTPUT_REG_EN
        test_registered();
        test_reset_mid();
`else
        test_boundaries();
        test_ripple();
        test_sweep_n3();
        test_sweep_n1();
        test_random_n8();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
